bit_stuffer: RTL and testbench
==============================

# bit_stuffer

Serial USB-transmit bit stuffer sitting directly downstream of the CRC stage and upstream of the NRZI encoder. Forwards the CRC stage's serial packet stream and inserts a 0 after every run of RUN_LEN consecutive 1s. Stalls the CRC stage with `pause` for one cycle per inserted bit. Re-frames the packet with start/end strobes for the NRZI encoder.

## Interface
- RUN_LEN, 6, count of consecutive 1s that forces a stuffed 0 (legal range 2..7).
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_in  input  1  serial bit from the CRC stage; sampled when accepted.
- start_b  input  1  1-cycle pulse; `s_in` in the same cycle is the first packet bit.
- endr_b  input  1  1-cycle pulse, arrives the cycle after the last bit; `s_in` is ignored in that cycle.
- pause  output  1  registered; high means the CRC stage must hold its bit this cycle.
- s_out  output  1  registered serial bit to the NRZI encoder.
- valid_out  output  1  `s_out` carries a packet bit this cycle.
- start_out  output  1  high with the first `valid_out` of a packet.
- end_out  output  1  1-cycle pulse after the last output bit; `valid_out` is 0 in that cycle.
- busy  output  1  high from packet acceptance until `end_out` is issued.
- err  output  1  1-cycle pulse on protocol violation (see Operation).

## Operation
- States:
  - IDLE: waiting for a packet.
  - RUN: accepting one bit per cycle.
  - STUFF: emitting a stuffed 0, upstream held.
  - END: emitting `end_out`.
- A bit is accepted when the state is IDLE with `start_b`=1, or the state is RUN with `endr_b`=0. Acceptance implies `pause`=0.
- Ones counter (3 bits):
  - Cleared on `start_b`.
  - Cleared when a 0 is accepted.
  - Cleared when a stuffed 0 is emitted.
  - Otherwise incremented on each accepted 1.
- Stuffing: when an accepted 1 makes the counter equal RUN_LEN, the next state is STUFF.
- IDLE transitions:
  - `start_b` -> RUN.
  - `endr_b` alone -> `err` pulse, stay IDLE.
- RUN transitions:
  - `endr_b` -> END.
  - Count reaches RUN_LEN -> STUFF.
  - Otherwise stay RUN.
- STUFF:
  - Loads 0 into `s_out` with `valid_out`=1.
  - If `endr_b` is seen in STUFF, set end_pend.
  - Exit to END if end_pend is set, else RUN.
- END: drives `end_out`=1 on the following cycle, clears end_pend and `busy`, returns to IDLE.
- Stuffing applies to every bit between start and end, including SYNC and CRC bits.
- `start_b` in RUN or STUFF:
  - `err` pulse.
  - Current packet is abandoned with no `end_out`.
  - The bit is accepted as the first bit of a new packet; counter restarts, `start_out` is reasserted.
- `start_b` and `endr_b` in the same cycle: `start_b` wins; `err` pulse.
- Asynchronous reset at any point:
  - State goes to IDLE, counter and end_pend cleared.
  - All outputs go to 0 immediately, with no glitch on `end_out`.

## Timing
- Bit accepted at cycle t appears on `s_out` with `valid_out`=1 at t+1 (latency 1).
- Sixth 1 accepted at t:
  - `pause`=1 during t+1.
  - Stuffed 0 on `s_out` at t+2.
  - Next upstream bit accepted at t+2, so the output stream has no gaps.
- `pause` is a Moore output (high only in STUFF), so the CRC stage may use it combinationally without forming a loop.
- `endr_b` at cycle e in RUN: `end_out` at e+1.
- `endr_b` at cycle e in STUFF: stuffed 0 at e+1, `end_out` at e+2.
- Minimum gap from `end_out` to the next accepted `start_b`: 0 cycles. `start_b` in the `end_out` cycle is legal.

## Structure
- Shared package `usb_tx_pkg`:
  - `RUN_LEN_DEFAULT` = 6.
  - Stuffer state enum.
  - `SYNC` constant (8'b0000_0001).
  - Packet-type codes shared with the CRC stage.
- One sub-module: reuse the existing `counter` as `counter #(3)` for the ones run (clr/en driven by the FSM). All other logic stays inline.

## Test plan
- Packet 0000_0001 then 0x00, no stuffing: `s_out` equals the input sequence delayed 1 cycle; `pause` never high; `end_out` 1 cycle after the last bit.
- Eight 1s: output is 1111110 then 11; `pause` high exactly once, 1 cycle after the sixth 1 is accepted.
- Pattern 11111 0 111111: counter resets on the 0; exactly one stuffed 0, after the final six 1s.
- Last payload bit completes six 1s, `endr_b` arrives during STUFF: stuffed 0 emitted, then `end_out` one cycle later; `busy` drops with `end_out`.
- `start_b` mid-packet after three bits: `err` pulse; no `end_out`; `start_out` reasserted at the next cycle; run count restarted (needs six new 1s to stuff).
- `rst_n` low during STUFF: all outputs 0 immediately; after release, a fresh packet of 111111 stuffs normally.

Source files
------------

// File: rtl/usb_tx_pkg.sv
// Shared definitions for the USB transmit path: stuffer state encoding,
// SYNC pattern and the packet-type codes agreed with the CRC stage.
package usb_tx_pkg;

    localparam int RUN_LEN_DEFAULT = 6;

    localparam logic [7:0] SYNC = 8'b0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STUFF = 2'd2,
        ST_END   = 2'd3
    } stuff_state_e;

    typedef enum logic [3:0] {
        PID_OUT   = 4'b0001,
        PID_IN    = 4'b1001,
        PID_SOF   = 4'b0101,
        PID_SETUP = 4'b1101,
        PID_DATA0 = 4'b0011,
        PID_DATA1 = 4'b1011,
        PID_ACK   = 4'b0010,
        PID_NAK   = 4'b1010,
        PID_STALL = 4'b1110
    } pid_e;

    // The PID byte on the wire carries the inverted code in its upper nibble.
    function automatic logic [7:0] pid_byte(input pid_e pid);
        return {~pid, pid};
    endfunction

endpackage

// File: rtl/counter.sv
// Up counter with synchronous clear. Clear and enable together restart the
// count at 1, so an event that both starts a run and counts in it is one step.
module counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);

    // NOTE: sequential state is only ever written with non-blocking assignments,
    // so every flop samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_count <= '0;
        end else if (i_clr) begin
            o_count <= i_en ? W'(1) : '0;
        end else if (i_en) begin
            o_count <= o_count + W'(1);
        end
    end

endmodule

// File: rtl/bit_stuffer.sv
// USB transmit bit stuffer: forwards the CRC stage's serial stream, inserts a 0
// after every RUN_LEN consecutive 1s and re-frames the packet for NRZI.
module bit_stuffer
    import usb_tx_pkg::*;
#(
    parameter int RUN_LEN = RUN_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s_in,
    input  logic start_b,
    input  logic endr_b,
    output logic pause,
    output logic s_out,
    output logic valid_out,
    output logic start_out,
    output logic end_out,
    output logic busy,
    output logic err
);

    localparam logic [2:0] RUN_LEN_W = 3'(RUN_LEN);

    stuff_state_e r_state;
    stuff_state_e w_state_nxt;
    logic         r_end_pend;
    logic         w_end_pend_nxt;

    logic r_pause;
    logic r_s_out;
    logic r_valid_out;
    logic r_start_out;
    logic r_end_out;
    logic r_busy;
    logic r_err;

    logic       w_accept;
    logic       w_stuff_hit;
    logic       w_cnt_clr;
    logic       w_cnt_en;
    logic       w_err_nxt;
    logic       w_end_out_nxt;
    logic       w_busy_nxt;
    logic [2:0] w_ones;
    logic [2:0] w_ones_nxt;

    // start_b always wins: it takes the bit even mid-packet and restarts framing.
    assign w_accept    = start_b || (r_state == ST_RUN && !endr_b);
    assign w_ones_nxt  = start_b ? 3'd1 : w_ones + 3'd1;
    assign w_stuff_hit = w_accept && s_in && (w_ones_nxt == RUN_LEN_W);

    assign w_cnt_en  = w_accept && s_in;
    assign w_cnt_clr = (w_accept && (start_b || !s_in))
                     || (r_state == ST_STUFF && !w_accept);

    counter #(
        .W(3)
    ) u_ones_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clr   (w_cnt_clr),
        .i_en    (w_cnt_en),
        .o_count (w_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_end_pend <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_end_pend <= w_end_pend_nxt;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        w_state_nxt    = r_state;
        w_end_pend_nxt = r_end_pend;
        w_err_nxt      = 1'b0;
        w_end_out_nxt  = 1'b0;

        if (start_b) begin
            w_state_nxt    = w_stuff_hit ? ST_STUFF : ST_RUN;
            w_end_pend_nxt = 1'b0;
            w_err_nxt      = endr_b
                          || r_state == ST_RUN
                          || r_state == ST_STUFF
                          || (r_state == ST_END && r_end_pend);
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    w_err_nxt = endr_b;
                end
                ST_RUN: begin
                    if (endr_b) begin
                        w_state_nxt   = ST_END;
                        w_end_out_nxt = 1'b1;
                    end else if (w_stuff_hit) begin
                        w_state_nxt = ST_STUFF;
                    end
                end
                ST_STUFF: begin
                    // End of packet seen while the stuffed 0 goes out: end_out
                    // is deferred one cycle through END with end_pend set.
                    if (endr_b || r_end_pend) begin
                        w_state_nxt    = ST_END;
                        w_end_pend_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_RUN;
                    end
                end
                ST_END: begin
                    w_state_nxt    = ST_IDLE;
                    w_end_pend_nxt = 1'b0;
                    w_end_out_nxt  = r_end_pend;
                    w_err_nxt      = endr_b && !r_end_pend;
                end
                default: begin
                    w_state_nxt    = ST_IDLE;
                    w_end_pend_nxt = 1'b0;
                end
            endcase
        end
    end

    // Busy covers the deferred-end cycle too, and falls with end_out.
    assign w_busy_nxt = (w_state_nxt == ST_RUN)
                     || (w_state_nxt == ST_STUFF)
                     || (w_state_nxt == ST_END && w_end_pend_nxt);

    // All outputs are flops so reset clears them at once and none can glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pause     <= 1'b0;
            r_s_out     <= 1'b0;
            r_valid_out <= 1'b0;
            r_start_out <= 1'b0;
            r_end_out   <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pause     <= (w_state_nxt == ST_STUFF);
            r_s_out     <= w_accept && s_in;
            r_valid_out <= w_accept || (r_state == ST_STUFF);
            r_start_out <= start_b;
            r_end_out   <= w_end_out_nxt;
            r_busy      <= w_busy_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign pause     = r_pause;
    assign s_out     = r_s_out;
    assign valid_out = r_valid_out;
    assign start_out = r_start_out;
    assign end_out   = r_end_out;
    assign busy      = r_busy;
    assign err       = r_err;

endmodule

// File: tb/tb_bit_stuffer.sv
// Directed bench for bit_stuffer: each step drives one cycle of inputs and
// checks the packed output word visible after the following rising edge.
module tb_bit_stuffer;

    logic clk     = 1'b0;
    logic rst_n   = 1'b1;
    logic s_in    = 1'b0;
    logic start_b = 1'b0;
    logic endr_b  = 1'b0;

    logic pause;
    logic s_out;
    logic valid_out;
    logic start_out;
    logic end_out;
    logic busy;
    logic err;

    int total = 0;
    int bad   = 0;

    // Output word: {pause, s_out, valid_out, start_out, end_out, busy, err}
    logic [6:0] w_obs;
    assign w_obs = {pause, s_out, valid_out, start_out, end_out, busy, err};

    localparam logic [6:0] O_IDLE    = 7'b000_0000;
    localparam logic [6:0] O_FIRST1  = 7'b011_1010;
    localparam logic [6:0] O_FIRST0  = 7'b001_1010;
    localparam logic [6:0] O_ONE     = 7'b011_0010;
    localparam logic [6:0] O_ZERO    = 7'b001_0010;
    localparam logic [6:0] O_PSTUFF  = 7'b111_0010;
    localparam logic [6:0] O_END     = 7'b000_0100;
    localparam logic [6:0] O_ERR     = 7'b000_0001;
    localparam logic [6:0] O_RESTART = 7'b011_1011;
    localparam logic [6:0] O_SE_ERR  = 7'b001_1011;

    bit_stuffer #(
        .RUN_LEN(6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_in      (s_in),
        .start_b   (start_b),
        .endr_b    (endr_b),
        .pause     (pause),
        .s_out     (s_out),
        .valid_out (valid_out),
        .start_out (start_out),
        .end_out   (end_out),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b (pause,s_out,valid,start,end,busy,err)",
                   tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic st, input logic s, input logic en,
                       input logic [6:0] exp, input string tag);
        start_b = st;
        s_in    = s;
        endr_b  = en;
        @(posedge clk);
        #1;
        check(tag, w_obs, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] pat;
        logic        b;

        #2 rst_n = 1'b0;
        #1 check("reset state", w_obs, O_IDLE);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        cyc(0, 0, 0, O_IDLE, "idle after reset");

        // Test 1: SYNC then 0x00, no stuffing, output is input delayed one cycle.
        pat = {8'b0000_0001, 8'h00};
        for (int k = 0; k < 16; k++) begin
            b = pat[15-k];
            if (k == 0) cyc(1, b, 0, b ? O_FIRST1 : O_FIRST0, "t1 first bit");
            else        cyc(0, b, 0, b ? O_ONE : O_ZERO, $sformatf("t1 bit %0d", k));
        end
        cyc(0, 0, 1, O_END, "t1 end_out");

        // Test 2: eight 1s, started in the end_out cycle of test 1 (legal, no err).
        cyc(1, 1, 0, O_FIRST1, "t2 start in end_out cycle");
        for (int k = 1; k < 5; k++) cyc(0, 1, 0, O_ONE, $sformatf("t2 one %0d", k));
        cyc(0, 1, 0, O_PSTUFF, "t2 sixth one pause");
        cyc(0, 1, 0, O_ZERO,   "t2 stuffed zero");
        cyc(0, 1, 0, O_ONE,    "t2 seventh one");
        cyc(0, 1, 0, O_ONE,    "t2 eighth one");
        cyc(0, 0, 1, O_END,    "t2 end_out");

        // Test 3: 11111 0 111111, the 0 restarts the run.
        cyc(1, 1, 0, O_FIRST1, "t3 first bit");
        for (int k = 1; k < 5; k++) cyc(0, 1, 0, O_ONE, $sformatf("t3 one %0d", k));
        cyc(0, 0, 0, O_ZERO, "t3 zero resets run");
        for (int k = 0; k < 5; k++) cyc(0, 1, 0, O_ONE, $sformatf("t3 run2 one %0d", k));
        cyc(0, 1, 0, O_PSTUFF, "t3 sixth one pause");
        cyc(0, 1, 0, O_ZERO,   "t3 stuffed zero");
        cyc(0, 0, 1, O_END,    "t3 end_out");
        cyc(0, 0, 0, O_IDLE,   "t3 idle");

        // Test 4: last bit completes the run, endr_b arrives during STUFF.
        cyc(1, 1, 0, O_FIRST1, "t4 first bit");
        for (int k = 1; k < 5; k++) cyc(0, 1, 0, O_ONE, $sformatf("t4 one %0d", k));
        cyc(0, 1, 0, O_PSTUFF, "t4 sixth one pause");
        cyc(0, 0, 1, O_ZERO,   "t4 stuffed zero busy held");
        cyc(0, 0, 0, O_END,    "t4 deferred end_out");
        cyc(0, 0, 0, O_IDLE,   "t4 idle");

        // Test 5: start_b after three bits abandons the packet and restarts the run.
        cyc(1, 1, 0, O_FIRST1, "t5 first bit");
        cyc(0, 1, 0, O_ONE,    "t5 one 1");
        cyc(0, 1, 0, O_ONE,    "t5 one 2");
        cyc(1, 1, 0, O_RESTART, "t5 restart err");
        for (int k = 0; k < 4; k++) cyc(0, 1, 0, O_ONE, $sformatf("t5 new one %0d", k));
        cyc(0, 1, 0, O_PSTUFF, "t5 sixth new one pause");
        cyc(0, 1, 0, O_ZERO,   "t5 stuffed zero");
        cyc(0, 0, 1, O_END,    "t5 end_out");
        cyc(0, 0, 0, O_IDLE,   "t5 idle");

        // Test 6: reset asserted while in STUFF, then a fresh packet stuffs normally.
        cyc(1, 1, 0, O_FIRST1, "t6 first bit");
        for (int k = 1; k < 5; k++) cyc(0, 1, 0, O_ONE, $sformatf("t6 one %0d", k));
        cyc(0, 1, 0, O_PSTUFF, "t6 in STUFF");
        rst_n   = 1'b0;
        start_b = 1'b0;
        s_in    = 1'b0;
        endr_b  = 1'b0;
        #1 check("t6 reset immediate", w_obs, O_IDLE);
        @(posedge clk);
        #1 check("t6 reset held", w_obs, O_IDLE);
        rst_n = 1'b1;
        cyc(0, 0, 0, O_IDLE, "t6 idle after release");
        cyc(1, 1, 0, O_FIRST1, "t6b first bit");
        for (int k = 1; k < 5; k++) cyc(0, 1, 0, O_ONE, $sformatf("t6b one %0d", k));
        cyc(0, 1, 0, O_PSTUFF, "t6b sixth one pause");
        cyc(0, 1, 0, O_ZERO,   "t6b stuffed zero");
        cyc(0, 0, 1, O_END,    "t6b end_out");
        cyc(0, 0, 0, O_IDLE,   "t6b idle");

        // Protocol violations from IDLE.
        cyc(0, 0, 1, O_ERR,    "endr alone in idle");
        cyc(0, 0, 0, O_IDLE,   "idle after err");
        cyc(1, 0, 1, O_SE_ERR, "start and endr together");
        cyc(0, 0, 1, O_END,    "end after start+endr");
        cyc(0, 0, 0, O_IDLE,   "final idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
